// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// burst directions and the burst-engine state type.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register; the rot signal
// exists only when USR_ROTATE_EN is defined.
interface univ_shift_reg_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    import usr_pkg::*;

    logic [1:0]       mode;
    logic [WIDTH-1:0] ins;
    logic             sin_r;
    logic             sin_l;
`ifdef USR_ROTATE_EN
    logic             rot;
`endif
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] outs;
    logic             sout_r;
    logic             sout_l;
    logic             busy;
    logic             done;

`ifdef USR_ROTATE_EN
    modport master (output mode, ins, sin_r, sin_l, rot, start, dir, cnt,
                    input  outs, sout_r, sout_l, busy, done);
    modport slave  (input  mode, ins, sin_r, sin_l, rot, start, dir, cnt,
                    output outs, sout_r, sout_l, busy, done);
`else
    modport master (output mode, ins, sin_r, sin_l, start, dir, cnt,
                    input  outs, sout_r, sout_l, busy, done);
    modport slave  (input  mode, ins, sin_r, sin_l, start, dir, cnt,
                    output outs, sout_r, sout_l, busy, done);
`endif

endinterface

// File: rtl/usr_shift_step.sv
// Combinational single-position shifter; the caller picks the fill bit,
// which is how both serial-in and rotate are expressed.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] value,
    input  logic             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        if (dir == DIR_LEFT) begin
            result = {value[WIDTH-2:0], fill};
        end else begin
            result = {fill, value[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with hold/shift/load modes and a self-timed
// burst engine. Define USR_ROTATE_EN to add the rot (rotate) input.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    univ_shift_reg_if.slave bus
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] outs_q;
    logic [WIDTH-1:0] next_outs;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] next_remaining;
    logic             burst_dir;
    logic             next_dir;
    logic             rot_sel;
    logic             step_dir;
    logic             step_fill;
    logic [WIDTH-1:0] step_result;

`ifdef USR_ROTATE_EN
    assign rot_sel = bus.rot;
`else
    assign rot_sel = 1'b0;
`endif

    // One shifter serves both paths: the latched direction during a burst,
    // otherwise the direction implied by the live mode.
    assign step_dir = (state == BURST) ? burst_dir
                    : ((bus.mode == MODE_SHL) ? DIR_LEFT : DIR_RIGHT);

    always_comb begin
        if (rot_sel) begin
            step_fill = (step_dir == DIR_LEFT) ? outs_q[WIDTH-1] : outs_q[0];
        end else begin
            step_fill = (step_dir == DIR_LEFT) ? bus.sin_l : bus.sin_r;
        end
    end

    usr_shift_step #(.WIDTH(WIDTH)) u_step (
        .value  (outs_q),
        .dir    (step_dir),
        .fill   (step_fill),
        .result (step_result)
    );

    always_comb begin
        next_state     = state;
        next_outs      = outs_q;
        next_remaining = remaining;
        next_dir       = burst_dir;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_dir       = bus.dir;
                    next_remaining = bus.cnt;
                    next_state     = BURST;
                end else begin
                    case (bus.mode)
                        MODE_SHR,
                        MODE_SHL:  next_outs = step_result;
                        MODE_LOAD: next_outs = bus.ins;
                        default:   next_outs = outs_q;
                    endcase
                end
            end
            BURST: begin
                if (remaining != '0) begin
                    next_outs      = step_result;
                    next_remaining = remaining - CNT_W'(1);
                end else begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            outs_q    <= '0;
            remaining <= '0;
            burst_dir <= DIR_RIGHT;
        end else begin
            state     <= next_state;
            outs_q    <= next_outs;
            remaining <= next_remaining;
            burst_dir <= next_dir;
        end
    end

    assign bus.outs   = outs_q;
    assign bus.sout_r = outs_q[0];
    assign bus.sout_l = outs_q[WIDTH-1];
    assign bus.busy   = (state == BURST);
    assign bus.done   = (state == DONE);

endmodule
